// File: rtl/hub75_capture.sv
// hub75_capture: snoops a HUB75 panel bus, rebuilds each latched row and streams it out with the
// bit plane decoded from the OE pulse width. Optional error counter: HUB75_CAPTURE_ERR_COUNT_EN.
module hub75_capture #(
   parameter int unsigned COLUMNS = 64,
   parameter int unsigned OE_UNIT = 4
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       hub_clk,
   input  logic       hub_lat,
   input  logic       hub_oe,
   input  logic [3:0] hub_addr,
   input  logic [2:0] hub_rgb1,
   input  logic [2:0] hub_rgb2,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [9:0] wr_addr,
   output logic [5:0] wr_data,
   output logic [2:0] wr_plane,
   output logic       overrun,
   output logic       framing_err,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {StIdle, StWaitOe, StMeasure, StDrain} state_e;

   localparam logic [6:0]  ColCount = 7'(COLUMNS);
   localparam logic [5:0]  LastCol  = 6'(COLUMNS - 1);
   localparam int unsigned Th1 = 2 * OE_UNIT;
   localparam int unsigned Th2 = 5 * OE_UNIT;
   localparam int unsigned Th3 = 12 * OE_UNIT;
   localparam int unsigned Th4 = 24 * OE_UNIT;
   localparam int unsigned Th5 = 48 * OE_UNIT;

   // Bus bits: {clk, lat, oe, addr[3:0], rgb2[2:0], rgb1[2:0]}
   logic [12:0] sync1_q, sync2_q;
   logic [2:0]  edge_q;
   logic        clk_rise, lat_rise, oe_rise, s_oe;
   logic [3:0]  s_addr;
   logic [5:0]  s_pix;

   state_e      state_q, state_d;
   logic [6:0]  shift_cnt_q, shift_cnt_cap;
   logic        cap_en, hold_load;
   logic [5:0]  shift_buf_q [COLUMNS];
   logic [5:0]  hold_buf_q [COLUMNS];
   logic [3:0]  row_q;
   logic [7:0]  width_q;
   logic [31:0] width_ext;
   logic [2:0]  plane_q, plane_dec;
   logic [5:0]  col_q;
   logic        overrun_q, framing_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         edge_q  <= '0;
      end else begin
         sync1_q <= {hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb2, hub_rgb1};
         sync2_q <= sync1_q;
         edge_q  <= sync2_q[12:10];
      end
   end

   assign clk_rise = sync2_q[12] & ~edge_q[2];
   assign lat_rise = sync2_q[11] & ~edge_q[1];
   assign oe_rise  = sync2_q[10] & ~edge_q[0];
   assign s_oe     = sync2_q[10];
   assign s_addr   = sync2_q[9:6];
   assign s_pix    = sync2_q[5:0];

   assign cap_en        = clk_rise && (shift_cnt_q < ColCount);
   assign shift_cnt_cap = cap_en ? shift_cnt_q + 7'd1 : shift_cnt_q;
   assign hold_load     = lat_rise && (state_q == StIdle);

   always_ff @(posedge clk_in) begin
      if (reset || lat_rise) begin
         shift_cnt_q <= '0;
      end else begin
         shift_cnt_q <= shift_cnt_cap;
      end
   end

   // A pixel arriving with the latch belongs to the row being latched.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < COLUMNS; i++) begin
         if (hold_load) begin
            hold_buf_q[i] <= (cap_en && shift_cnt_q == 7'(i)) ? s_pix : shift_buf_q[i];
         end
         if (lat_rise) begin
            shift_buf_q[i] <= '0;
         end else if (cap_en && shift_cnt_q == 7'(i)) begin
            shift_buf_q[i] <= s_pix;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         overrun_q <= 1'b0;
         framing_q <= 1'b0;
      end else begin
         overrun_q <= lat_rise && (state_q != StIdle);
         framing_q <= lat_rise && (shift_cnt_cap != ColCount);
      end
   end

   assign overrun     = overrun_q;
   assign framing_err = framing_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (lat_rise) state_d = StWaitOe;
         StWaitOe:  if (oe_rise) state_d = StMeasure;
         StMeasure: if (!s_oe) state_d = StDrain;
         StDrain:   if (wr_ready && col_q == LastCol) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   assign width_ext = {24'd0, width_q};

   // Thresholds are the source-cycle bounds scaled by OE_UNIT, avoiding a divider.
   always_comb begin
      if (width_ext < Th1)      plane_dec = 3'd0;
      else if (width_ext < Th2) plane_dec = 3'd1;
      else if (width_ext < Th3) plane_dec = 3'd2;
      else if (width_ext < Th4) plane_dec = 3'd3;
      else if (width_ext < Th5) plane_dec = 3'd4;
      else                      plane_dec = 3'd5;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         row_q   <= '0;
         width_q <= '0;
         plane_q <= '0;
         col_q   <= '0;
      end else begin
         case (state_q)
            StWaitOe: begin
               if (oe_rise) begin
                  row_q   <= s_addr;
                  width_q <= 8'd1;
               end
            end
            StMeasure: begin
               if (s_oe) begin
                  if (width_q != 8'hff) width_q <= width_q + 8'd1;
               end else begin
                  plane_q <= plane_dec;
                  col_q   <= '0;
               end
            end
            StDrain: if (wr_ready) col_q <= col_q + 6'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_plane = '0;
      if (state_q == StDrain) begin
         wr_valid = 1'b1;
         wr_addr  = {row_q, col_q};
         wr_data  = hold_buf_q[LastCol - col_q];
         wr_plane = plane_q;
      end
   end

`ifdef HUB75_CAPTURE_ERR_COUNT_EN
   logic [7:0] err_count_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         err_count_q <= '0;
      end else if ((overrun_q || framing_q) && err_count_q != 8'hff) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign err_count = err_count_q;
`else
   assign err_count = 8'd0;
`endif

endmodule
